// File: rtl/lms_log2_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lms_log2_sched: shares one log2 LUT across the L, M, S channels          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lms_log2_sched #(
  parameter int W_IN    = 16,
  parameter int W_OUT   = 16,
  parameter int IDX_MAX = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W_IN-1:0]  i_L,
  input  logic [W_IN-1:0]  i_M,
  input  logic [W_IN-1:0]  i_S,
  output logic [W_IN-1:0]  o_log2_index,
  input  logic [W_OUT-1:0] i_log2_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W_OUT-1:0] o_log_L,
  output logic [W_OUT-1:0] o_log_M,
  output logic [W_OUT-1:0] o_log_S,
  output logic [2:0]       o_clip,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN_L = 3'd1,
    RUN_M = 3'd2,
    RUN_S = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [W_IN-1:0] c_idx_max = W_IN'(IDX_MAX);

  state_t            state_q, state_d;
  logic [W_IN-1:0]   idx_q, idx_d;
  logic [W_IN-1:0]   m_q, m_d;
  logic [W_IN-1:0]   s_q, s_d;
  logic [W_OUT-1:0]  log_l_q, log_l_d;
  logic [W_OUT-1:0]  log_m_q, log_m_d;
  logic [W_OUT-1:0]  log_s_q, log_s_d;
  logic [2:0]        clip_q, clip_d;

  logic [2:0]        w_clip;
  logic [W_IN-1:0]   w_l, w_m, w_s;
  logic              w_capture;

  always_comb begin
    w_clip = {(i_S > c_idx_max), (i_M > c_idx_max), (i_L > c_idx_max)};
    w_l    = w_clip[0] ? c_idx_max : i_L;
    w_m    = w_clip[1] ? c_idx_max : i_M;
    w_s    = w_clip[2] ? c_idx_max : i_S;
  end

  // The index is registered one step ahead so it is valid throughout each RUN cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = '0;
    m_d       = m_q;
    s_d       = s_q;
    log_l_d   = log_l_q;
    log_m_d   = log_m_q;
    log_s_d   = log_s_q;
    clip_d    = clip_q;
    o_ready   = 1'b0;
    w_capture = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready   = 1'b1;
        w_capture = i_valid;
      end
      RUN_L: begin
        log_l_d = i_log2_result;
        idx_d   = m_q;
        state_d = RUN_M;
      end
      RUN_M: begin
        log_m_d = i_log2_result;
        idx_d   = s_q;
        state_d = RUN_S;
      end
      RUN_S: begin
        log_s_d = i_log2_result;
        state_d = HOLD;
      end
      HOLD: begin
        o_ready = i_ready;
        if (i_ready) begin
          w_capture = i_valid;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_capture) begin
      idx_d   = w_l;
      m_d     = w_m;
      s_d     = w_s;
      clip_d  = w_clip;
      state_d = RUN_L;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      m_q     <= '0;
      s_q     <= '0;
      log_l_q <= '0;
      log_m_q <= '0;
      log_s_q <= '0;
      clip_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      s_q     <= s_d;
      log_l_q <= log_l_d;
      log_m_q <= log_m_d;
      log_s_q <= log_s_d;
      clip_q  <= clip_d;
    end
  end

  assign o_log2_index = idx_q;
  assign o_valid      = (state_q == HOLD);
  assign o_busy       = (state_q != IDLE);
  assign o_log_L      = log_l_q;
  assign o_log_M      = log_m_q;
  assign o_log_S      = log_s_q;
  assign o_clip       = clip_q;

endmodule
`default_nettype wire

// File: tb/tb_lms_log2_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lms_log2_sched: directed vectors plus stall/back-to-back/reset cases  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lms_log2_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, o_valid, i_ready, o_busy;
  logic [15:0] i_L, i_M, i_S, o_log2_index, lut_res;
  logic [15:0] o_log_L, o_log_M, o_log_S;
  logic [2:0]  o_clip;

  always #5 clk = ~clk;

  lms_log2_sched dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_L(i_L), .i_M(i_M), .i_S(i_S), .o_log2_index(o_log2_index),
    .i_log2_result(lut_res), .o_valid(o_valid), .i_ready(i_ready),
    .o_log_L(o_log_L), .o_log_M(o_log_M), .o_log_S(o_log_S),
    .o_clip(o_clip), .o_busy(o_busy)
  );

  // log2 in 3.13 for the indices the vectors exercise
  function automatic logic [15:0] lut(input logic [15:0] idx);
    case (idx)
      16'd0, 16'd1: lut = 16'h0000;
      16'd2:   lut = 16'h2000;
      16'd4:   lut = 16'h4000;
      16'd8:   lut = 16'h6000;
      16'd16:  lut = 16'h8000;
      16'd32:  lut = 16'hA000;
      16'd64:  lut = 16'hC000;
      16'd128: lut = 16'hE000;
      16'd192: lut = 16'hF2B8;
      16'd255: lut = 16'hFFD2;
      default: lut = 16'h1234;
    endcase
  endfunction

  assign lut_res = lut(o_log2_index);

  typedef struct {
    logic [15:0] l, m, s;
    logic [15:0] il, im, is;
    logic [15:0] el, em, es;
    logic [2:0]  clip;
  } vec_t;

  vec_t vecs[5];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [15:0] l, input logic [15:0] m, input logic [15:0] s);
    i_L = l; i_M = m; i_S = s;
  endtask

  task automatic check_hold(input string tag, input vec_t v);
    check({tag, " o_valid"}, o_valid, 1);
    check({tag, " log_L"}, o_log_L, v.el);
    check({tag, " log_M"}, o_log_M, v.em);
    check({tag, " log_S"}, o_log_S, v.es);
    check({tag, " clip"}, o_clip, v.clip);
  endtask

  // Starts and ends 1 time unit after a rising edge with the DUT idle.
  task automatic run_vec(input vec_t v);
    i_ready = 1'b1;
    i_valid = 1'b1;
    drive(v.l, v.m, v.s);
    @(posedge clk); #1;
    i_valid = 1'b0;
    drive(16'hAAAA, 16'h0003, 16'h0040);
    @(negedge clk);
    check("idx_L", o_log2_index, v.il);
    check("run o_valid", o_valid, 0);
    check("run busy", o_busy, 1);
    check("run o_ready", o_ready, 0);
    @(negedge clk);
    check("idx_M", o_log2_index, v.im);
    @(negedge clk);
    check("idx_S", o_log2_index, v.is);
    @(negedge clk);
    check_hold("vec", v);
    check("hold o_ready", o_ready, 1);
    check("hold idx", o_log2_index, 0);
    @(negedge clk);
    check("idle o_valid", o_valid, 0);
    check("idle o_ready", o_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{16'd128, 16'd192, 16'd16,   16'd128, 16'd192, 16'd16,
                16'hE000, 16'hF2B8, 16'h8000, 3'b000};
    vecs[1] = '{16'd300, 16'd255, 16'd8,    16'd255, 16'd255, 16'd8,
                16'hFFD2, 16'hFFD2, 16'h6000, 3'b001};
    vecs[2] = '{16'd1,   16'd300, 16'd1000, 16'd1,   16'd255, 16'd255,
                16'h0000, 16'hFFD2, 16'hFFD2, 3'b110};
    vecs[3] = '{16'd64,  16'd32,  16'd4,    16'd64,  16'd32,  16'd4,
                16'hC000, 16'hA000, 16'h4000, 3'b000};
    vecs[4] = '{16'd0,   16'd2,   16'd256,  16'd0,   16'd2,   16'd255,
                16'h0000, 16'h2000, 16'hFFD2, 3'b100};

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    drive(16'd0, 16'd0, 16'd0);
    #12;
    check("rst o_valid", o_valid, 0);
    check("rst o_ready", o_ready, 1);
    check("rst busy", o_busy, 0);
    check("rst idx", o_log2_index, 0);
    check("rst logs", {o_log_L, o_log_M}, 0);
    check("rst log_S/clip", {o_log_S, o_clip}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Downstream stall with a competing request
    i_ready = 1'b0;
    i_valid = 1'b1;
    drive(vecs[0].l, vecs[0].m, vecs[0].s);
    @(posedge clk); #1;
    drive(vecs[3].l, vecs[3].m, vecs[3].s);
    repeat (3) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_hold("stall", vecs[0]);
      check("stall o_ready", o_ready, 0);
      @(posedge clk);
    end
    #1 i_ready = 1'b1;
    @(negedge clk);
    check("unstall o_ready", o_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    drive(16'd5, 16'd6, 16'd7);
    @(negedge clk);
    check("post-stall idx_L", o_log2_index, 64);
    check("post-stall o_valid", o_valid, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_hold("post-stall", vecs[3]);
    @(posedge clk); #1;

    // Back-to-back triples with i_valid held high
    i_ready = 1'b1;
    i_valid = 1'b1;
    drive(vecs[1].l, vecs[1].m, vecs[1].s);
    @(posedge clk); #1;
    drive(vecs[4].l, vecs[4].m, vecs[4].s);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 5) i_valid = 1'b0;
      check($sformatf("b2b o_valid c%0d", c), o_valid, (c == 4 || c == 8) ? 1 : 0);
      if (c == 1) check("b2b idx first", o_log2_index, vecs[1].il);
      if (c == 4) check_hold("b2b first", vecs[1]);
      if (c == 6) check("b2b idx second", o_log2_index, vecs[4].im);
      if (c == 8) check_hold("b2b second", vecs[4]);
    end
    @(posedge clk); #1;

    // Asynchronous reset during RUN_M
    i_valid = 1'b1;
    drive(vecs[0].l, vecs[0].m, vecs[0].s);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-rst idx_M", o_log2_index, 192);
    #2 rst_n = 1'b0;
    #1;
    check("midrst o_valid", o_valid, 0);
    check("midrst log_L", o_log_L, 0);
    check("midrst log_M", o_log_M, 0);
    check("midrst log_S", o_log_S, 0);
    check("midrst idx", o_log2_index, 0);
    check("midrst busy", o_busy, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("postrst o_valid", o_valid, 0);
      check("postrst o_ready", o_ready, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
